// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op codes, burst state, op classification.
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_SHL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_ASR  = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Only shift/rotate ops can be repeated as a burst.
  function automatic logic is_burst_op(input mode_t m);
    return (m >= MODE_SHR) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_shift_op.sv
// Combinational next-value generator for one step of any register op.
module usr_shift_op
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_t            op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_nxt_c
);

  always_comb begin
    q_nxt_c = q;
    case (op)
      MODE_HOLD: q_nxt_c = q;
      MODE_LOAD: q_nxt_c = d;
      MODE_SHR:  q_nxt_c = {ser_in_l, q[WIDTH-1:1]};
      MODE_SHL:  q_nxt_c = {q[WIDTH-2:0], ser_in_r};
      MODE_ROR:  q_nxt_c = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_nxt_c = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  q_nxt_c = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_nxt_c = '0;
      default:   q_nxt_c = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a counted burst engine (Busy/Done handshake).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_t            op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_t            op_sel;
  logic [WIDTH-1:0] shift_q_c;
  logic             burst_req;

  // During a burst the latched op drives the datapath; otherwise the live Mode does.
  assign op_sel    = (state_q == RUN) ? op_q : mode_t'(Mode);
  assign burst_req = Start && is_burst_op(mode_t'(Mode));

  usr_shift_op #(
    .WIDTH(WIDTH)
  ) u_shift_op (
    .op      (op_sel),
    .q       (q_q),
    .d       (D),
    .ser_in_l(SerInL),
    .ser_in_r(SerInR),
    .q_nxt_c (shift_q_c)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_req && (Count != '0)) state_d = RUN;
      RUN:     if (En && (cnt_q <= CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_req) begin
          op_d   = mode_t'(Mode);
          cnt_d  = Count;
          busy_d = (Count != '0);
          done_d = (Count == '0);
        end else if (En) begin
          q_d = shift_q_c;
        end
      end
      RUN: begin
        if (En) begin
          q_d = shift_q_c;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign Q       = q_q;
  assign SerOutL = q_q[WIDTH-1];
  assign SerOutR = q_q[0];
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios then random traffic against a behavioural model.
module tb_univ_shift_reg;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       En;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       SerInL;
  logic       SerInR;
  logic       Start;
  logic [3:0] Count;
  logic [7:0] Q;
  logic       SerOutL;
  logic       SerOutR;
  logic       Busy;
  logic       Done;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  int done_cnt;

  logic [7:0] m_q;
  bit         m_busy;
  bit         m_done;
  int         m_rem;
  logic [2:0] m_op;

  univ_shift_reg #(
    .WIDTH    (8),
    .CNT_W    (4),
    .RESET_VAL(8'hA5)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .En     (En),
    .Mode   (Mode),
    .D      (D),
    .SerInL (SerInL),
    .SerInR (SerInR),
    .Start  (Start),
    .Count  (Count),
    .Q      (Q),
    .SerOutL(SerOutL),
    .SerOutR(SerOutR),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  // One op computed with integer arithmetic on the register value.
  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] q,
                                        input logic [7:0] d, input logic sl, input logic sr);
    int v;
    v = int'(q);
    case (op)
      3'd0: v = v;
      3'd1: v = int'(d);
      3'd2: v = (v / 2) + (sl ? 128 : 0);
      3'd3: v = ((v * 2) % 256) + (sr ? 1 : 0);
      3'd4: v = (v / 2) + ((v % 2) * 128);
      3'd5: v = ((v * 2) % 256) + (v / 128);
      3'd6: v = (v / 2) + ((v >= 128) ? 128 : 0);
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_q    = 8'hA5;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rem  = 0;
    m_op   = 3'd0;
  endtask

  task automatic model_edge();
    bit new_done;
    new_done = 1'b0;
    if (!m_busy) begin
      if (Start && (Mode >= 3'd2) && (Mode <= 3'd6)) begin
        m_op = Mode;
        if (Count == 4'd0) new_done = 1'b1;
        else begin
          m_busy = 1'b1;
          m_rem  = int'(Count);
        end
      end else if (En) begin
        m_q = ref_op(Mode, m_q, D, SerInL, SerInR);
      end
    end else if (En) begin
      m_q   = ref_op(m_op, m_q, D, SerInL, SerInR);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy   = 1'b0;
        new_done = 1'b1;
      end
    end
    m_done = new_done;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/Q"},       32'(Q),       32'(m_q));
    chk({tag, "/Busy"},    32'(Busy),    32'(m_busy));
    chk({tag, "/Done"},    32'(Done),    32'(m_done));
    chk({tag, "/SerOutL"}, 32'(SerOutL), 32'(m_q[7]));
    chk({tag, "/SerOutR"}, 32'(SerOutR), 32'(m_q[0]));
  endtask

  task automatic step(input string tag, input logic en_i, input logic [2:0] mode_i,
                      input logic [7:0] d_i, input logic sl_i, input logic sr_i,
                      input logic start_i, input logic [3:0] cnt_i);
    En     = en_i;
    Mode   = mode_i;
    D      = d_i;
    SerInL = sl_i;
    SerInR = sr_i;
    Start  = start_i;
    Count  = cnt_i;
    @(posedge Clk);
    model_edge();
    #1;
    if (Busy) busy_cnt++;
    if (Done) done_cnt++;
    check_all(tag);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Mode = 3'd0; D = 8'h00;
    SerInL = 1'b0; SerInR = 1'b0; Start = 1'b0; Count = 4'd0;
    model_reset();
    busy_cnt = 0; done_cnt = 0;
    #12;
    check_all("reset");
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Rotates and arithmetic shift on a loaded pattern
    step("load81", 1, 3'd1, 8'h81, 0, 0, 0, 4'd0);
    step("ror",    1, 3'd4, 8'h00, 0, 0, 0, 4'd0);
    chk("ror_val", 32'(Q), 32'h0C0);
    step("rol",    1, 3'd5, 8'h00, 0, 0, 0, 4'd0);
    chk("rol_val", 32'(Q), 32'h081);
    step("asr",    1, 3'd6, 8'h00, 0, 0, 0, 4'd0);
    chk("asr_val", 32'(Q), 32'h0C0);
    step("en_low", 0, 3'd4, 8'h00, 0, 0, 0, 4'd0);

    // Plain SHL burst of 3
    step("load0f", 1, 3'd1, 8'h0F, 0, 0, 0, 4'd0);
    busy_cnt = 0; done_cnt = 0;
    step("b3_start", 1, 3'd3, 8'h00, 0, 1, 1, 4'd3);
    for (int i = 0; i < 3; i++) step("b3_run", 1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b3_after", 1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    chk("b3_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("b3_done_pulses", 32'(done_cnt), 32'd1);
    chk("b3_final_q", 32'(Q), 32'h07F);

    // Same burst with two stalled cycles
    step("load0f_b", 1, 3'd1, 8'h0F, 0, 0, 0, 4'd0);
    busy_cnt = 0; done_cnt = 0;
    step("b5_start", 1, 3'd3, 8'h00, 0, 1, 1, 4'd3);
    step("b5_run1",  1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b5_stall", 0, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b5_stall", 0, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b5_run2",  1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b5_run3",  1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    step("b5_after", 1, 3'd0, 8'h00, 0, 1, 0, 4'd0);
    chk("b5_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("b5_done_pulses", 32'(done_cnt), 32'd1);
    chk("b5_final_q", 32'(Q), 32'h07F);

    // Zero-length burst, and Start with a non-burst op
    step("load3c", 1, 3'd1, 8'h3C, 0, 0, 0, 4'd0);
    step("cnt0",   1, 3'd2, 8'h00, 1, 1, 1, 4'd0);
    chk("cnt0_busy", 32'(Busy), 32'd0);
    chk("cnt0_done", 32'(Done), 32'd1);
    chk("cnt0_q",    32'(Q),    32'h03C);
    step("start_load", 1, 3'd1, 8'h5A, 0, 0, 1, 4'd5);
    chk("start_load_q",    32'(Q),    32'h05A);
    chk("start_load_busy", 32'(Busy), 32'd0);

    // Start/Mode changes during RUN ignored; restart in the Done cycle
    step("r6_start", 1, 3'd4, 8'h00, 0, 0, 1, 4'd3);
    step("r6_ign1",  1, 3'd1, 8'hFF, 0, 0, 1, 4'd7);
    step("r6_ign2",  1, 3'd7, 8'h00, 1, 1, 1, 4'd2);
    step("r6_last",  1, 3'd3, 8'h00, 1, 1, 0, 4'd0);
    chk("r6_ror3_q", 32'(Q),    32'h04B);
    chk("r6_done",   32'(Done), 32'd1);
    step("r6_restart", 1, 3'd5, 8'h00, 0, 0, 1, 4'd2);
    chk("r6_restart_busy", 32'(Busy), 32'd1);
    step("r6_rol1", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    step("r6_rol2", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    chk("r6_rol2_q", 32'(Q), 32'h02D);

    // Asynchronous reset in the middle of a long burst
    step("rst_start", 1, 3'd5, 8'h00, 0, 0, 1, 4'd8);
    step("rst_run",   1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    step("rst_run",   1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge Clk); #1;
    Reset = 1'b0;
    step("rst_after", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    step("rst_after", 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    chk("rst_after_q", 32'(Q), 32'h0A5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
